// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Trap/return sequencer. Latches sepc/scause/stvec, issues a
//               one-cycle PC redirect with pipeline flush, serves CSRRS.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter logic [31:0] STVEC_RESET  = 32'h0000_0100,
    parameter logic [11:0] CSR_STVEC    = 12'h105,
    parameter logic [11:0] CSR_SEPC     = 12'h141,
    parameter logic [11:0] CSR_SCAUSE   = 12'h142,
    parameter logic [7:0]  DFAULT_CAUSE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    input  logic        int_signal,
    input  logic [7:0]  scause_in,
    input  logic        mret,
    input  logic        csrrs,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_set,
    input  logic        csr_set_en,
    input  logic        stall,
    output logic [31:0] csr_rdata,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        in_trap,
    output logic        double_fault,
    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] sepc_q, sepc_d;
    logic [31:0] scause_q, scause_d;
    logic [31:0] stvec_q, stvec_d;
    logic        in_trap_q, in_trap_d;
    logic        double_fault_q, double_fault_d;

    logic        w_sample;
    logic        w_take_trap;
    logic        w_take_ret;
    logic        w_take_csr;

    // Priority: trap beats return beats CSR write, so a trap-entry write of
    // sepc/scause can never collide with a CSRRS write on the same edge.
    always_comb begin
        w_sample    = (state_q == IDLE) && req_valid && !stall;
        w_take_trap = w_sample && int_signal;
        w_take_ret  = w_sample && !int_signal && mret;
        w_take_csr  = w_sample && !int_signal && !mret && csrrs && csr_set_en;
    end

    always_comb begin
        case (csr_addr)
            CSR_STVEC:  csr_rdata = stvec_q;
            CSR_SEPC:   csr_rdata = sepc_q;
            CSR_SCAUSE: csr_rdata = scause_q;
            default:    csr_rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d          = IDLE;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        double_fault_d   = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        sepc_d           = sepc_q;
        scause_d         = scause_q;
        stvec_d          = stvec_q;
        in_trap_d        = in_trap_q;

        if (w_take_trap) begin
            state_d          = REDIR;
            flush_d          = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = stvec_q;
            if (!in_trap_q) begin
                sepc_d    = req_pc;
                scause_d  = {24'h0, scause_in};
                in_trap_d = 1'b1;
            end else begin
                scause_d       = {24'h0, DFAULT_CAUSE};
                double_fault_d = 1'b1;
            end
        end else if (w_take_ret) begin
            state_d          = REDIR;
            flush_d          = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = sepc_q;
            in_trap_d        = 1'b0;
        end else if (w_take_csr) begin
            case (csr_addr)
                CSR_STVEC:  stvec_d  = (stvec_q | csr_set) & ~32'h3;
                CSR_SEPC:   sepc_d   = sepc_q | csr_set;
                CSR_SCAUSE: scause_d = scause_q | csr_set;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
            sepc_q           <= 32'h0;
            scause_q         <= 32'h0;
            stvec_q          <= STVEC_RESET;
            in_trap_q        <= 1'b0;
            double_fault_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            sepc_q           <= sepc_d;
            scause_q         <= scause_d;
            stvec_q          <= stvec_d;
            in_trap_q        <= in_trap_d;
            double_fault_q   <= double_fault_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign in_trap        = in_trap_q;
    assign double_fault   = double_fault_q;
    assign busy           = (state_q == REDIR);

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Self-checking bench for trap_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        int_signal;
    logic [7:0]  scause_in;
    logic        mret;
    logic        csrrs;
    logic [11:0] csr_addr;
    logic [31:0] csr_set;
    logic        csr_set_en;
    logic        stall;
    logic [31:0] csr_rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        in_trap;
    logic        double_fault;
    logic        busy;

    int total = 0;
    int bad   = 0;

    trap_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
        .int_signal(int_signal), .scause_in(scause_in), .mret(mret),
        .csrrs(csrrs), .csr_addr(csr_addr), .csr_set(csr_set),
        .csr_set_en(csr_set_en), .stall(stall), .csr_rdata(csr_rdata),
        .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .in_trap(in_trap),
        .double_fault(double_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: CSR file as an associative array keyed by address, plus the
    // visible result of the most recent edge.
    logic [31:0] m_csr [int];
    bit          m_redirecting;
    bit          m_flush;
    logic [31:0] m_rpc;
    bit          m_in_trap;
    bit          m_df;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        if (m_csr.exists(int'(a))) return m_csr[int'(a)];
        return 32'h0;
    endfunction

    task automatic m_reset();
        m_csr.delete();
        m_csr[12'h105] = 32'h100;
        m_csr[12'h141] = 32'h0;
        m_csr[12'h142] = 32'h0;
        m_redirecting = 0;
        m_flush = 0;
        m_rpc = 32'h0;
        m_in_trap = 0;
        m_df = 0;
    endtask

    // One clock edge of the architectural rules.
    task automatic m_edge(input bit v, input logic [31:0] pc, input bit it,
                          input logic [7:0] c, input bit mr, input bit cs,
                          input logic [11:0] a, input logic [31:0] s,
                          input bit se, input bit st);
        bit accepted;
        accepted = !m_redirecting && v && !st;
        m_flush = 0;
        m_df = 0;
        if (m_redirecting) begin
            m_redirecting = 0;
        end else if (accepted && it) begin
            m_redirecting = 1;
            m_flush = 1;
            m_rpc = m_csr[12'h105];
            if (m_in_trap) begin
                m_csr[12'h142] = 32'hFF;
                m_df = 1;
            end else begin
                m_csr[12'h141] = pc;
                m_csr[12'h142] = 32'(c);
                m_in_trap = 1;
            end
        end else if (accepted && mr) begin
            m_redirecting = 1;
            m_flush = 1;
            m_rpc = m_csr[12'h141];
            m_in_trap = 0;
        end else if (accepted && cs && se && m_csr.exists(int'(a))) begin
            m_csr[int'(a)] = m_csr[int'(a)] | s;
            if (a == 12'h105) m_csr[int'(a)] = m_csr[int'(a)] & 32'hFFFF_FFFC;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("flush", 32'(flush), 32'(m_flush));
        chk("redirect_valid", 32'(redirect_valid), 32'(m_flush));
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("in_trap", 32'(in_trap), 32'(m_in_trap));
        chk("double_fault", 32'(double_fault), 32'(m_df));
        chk("busy", 32'(busy), 32'(m_redirecting));
    endtask

    // Drive one cycle's request, check the combinational read, step the edge,
    // then check registered outputs on the following falling edge.
    task automatic drive(input bit v, input logic [31:0] pc, input bit it,
                         input logic [7:0] c, input bit mr, input bit cs,
                         input logic [11:0] a, input logic [31:0] s,
                         input bit se, input bit st);
        req_valid = v; req_pc = pc; int_signal = it; scause_in = c;
        mret = mr; csrrs = cs; csr_addr = a; csr_set = s;
        csr_set_en = se; stall = st;
        #1;
        chk("csr_rdata", csr_rdata, m_read(a));
        @(posedge clk);
        m_edge(v, pc, it, c, mr, cs, a, s, se, st);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 8'h0, 0, 0, 12'h0, 32'h0, 0, 0);
    endtask

    task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(name, csr_rdata, exp);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        m_reset();
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] addrs [4];
        addrs[0] = 12'h105; addrs[1] = 12'h141; addrs[2] = 12'h142; addrs[3] = 12'h300;
        rst = 1'b1;
        req_valid = 0; req_pc = 0; int_signal = 0; scause_in = 0; mret = 0;
        csrrs = 0; csr_addr = 0; csr_set = 0; csr_set_en = 0; stall = 0;
        m_reset();
        @(negedge clk);
        check_all();
        chk("reset_flush", 32'(flush), 32'h0);
        peek("reset_stvec", 12'h105, 32'h100);
        rst = 1'b0;

        // ecall
        drive(1, 32'h40, 1, 8'h08, 0, 0, 12'h0, 32'h0, 0, 0);
        chk("ecall_flush", 32'(flush), 32'h1);
        chk("ecall_rpc", redirect_pc, 32'h100);
        chk("ecall_in_trap", 32'(in_trap), 32'h1);
        peek("ecall_sepc", 12'h141, 32'h40);
        peek("ecall_scause", 12'h142, 32'h08);
        idle();
        chk("ecall_t2_flush", 32'(flush), 32'h0);

        // mret
        drive(1, 32'h44, 0, 8'h0, 1, 0, 12'h0, 32'h0, 0, 0);
        chk("mret_rpc", redirect_pc, 32'h40);
        chk("mret_flush", 32'(flush), 32'h1);
        chk("mret_in_trap", 32'(in_trap), 32'h0);
        idle();

        // nested trap
        drive(1, 32'h80, 1, 8'h08, 0, 0, 12'h0, 32'h0, 0, 0);
        idle();
        drive(1, 32'h90, 1, 8'h02, 0, 0, 12'h0, 32'h0, 0, 0);
        chk("dfault_pulse", 32'(double_fault), 32'h1);
        peek("dfault_scause", 12'h142, 32'hFF);
        peek("dfault_sepc", 12'h141, 32'h80);
        idle();
        chk("dfault_drop", 32'(double_fault), 32'h0);
        drive(1, 32'h94, 0, 8'h0, 1, 0, 12'h0, 32'h0, 0, 0);
        idle();

        // CSRRS to stvec, then ecall uses it
        drive(1, 32'h100, 0, 8'h0, 0, 1, 12'h105, 32'h203, 1, 0);
        chk("csrrs_no_redirect", 32'(redirect_valid), 32'h0);
        peek("csrrs_stvec", 12'h105, 32'h300);
        drive(1, 32'h104, 1, 8'h08, 0, 0, 12'h0, 32'h0, 0, 0);
        chk("stvec_rpc", redirect_pc, 32'h300);
        idle();
        drive(1, 32'h300, 0, 8'h0, 1, 0, 12'h0, 32'h0, 0, 0);
        idle();

        // stalled ecall
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h200, 1, 8'h08, 0, 0, 12'h0, 32'h0, 0, 1);
            chk("stall_no_redirect", 32'(redirect_valid), 32'h0);
        end
        drive(1, 32'h200, 1, 8'h08, 0, 0, 12'h0, 32'h0, 0, 0);
        chk("unstall_redirect", 32'(redirect_valid), 32'h1);
        chk("unstall_rpc", redirect_pc, 32'h300);

        // reset during REDIR
        pulse_reset();
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_rv", 32'(redirect_valid), 32'h0);
        chk("rst_in_trap", 32'(in_trap), 32'h0);
        peek("rst_stvec", 12'h105, 32'h100);
        peek("rst_scause", 12'h142, 32'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] set_v;
            set_v = $urandom;
            if ($urandom_range(0, 3) != 0) set_v = set_v & (32'h1 << $urandom_range(0, 31));
            drive($urandom_range(0, 9) < 8,
                  $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 99) < 15,
                  8'($urandom),
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 40,
                  addrs[$urandom_range(0, 3)],
                  set_v,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
